frame_buffer_pingpong: RTL and testbench
========================================

# frame_buffer_pingpong

Parametrised double-buffered frame memory that replaces the single-bank pixel RAM between the scene writer and `st7789_painter`. It holds two full frames of `CHANNELS` × `CHANNEL_WIDTH` pixels. The painter always reads the front bank, while writers and a built-in clear engine only touch the back bank. Bank swaps are requested by the writer and take effect only at the painter's frame boundary, so tearing is impossible.

## Interface

Parameters:
- `X_LIMIT`, 240: pixels per line.
- `Y_LIMIT`, 240: lines per frame.
- `CHANNELS`, 3: colour channels per pixel. Channel 0 occupies the LSBs.
- `CHANNEL_WIDTH`, 8: bits per channel.
- Derived values: `PIXEL_LIMIT` = `X_LIMIT`*`Y_LIMIT`; `AW` = $clog2(`PIXEL_LIMIT`); `DW` = `CHANNELS`*`CHANNEL_WIDTH`.

Ports:
- `CLK`  in  1  single clock; all logic is on its rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `WRITE_RAM_ADDRESS`  in  `AW`  linear back-bank address, y*`X_LIMIT`+x.
- `WRITE_RAM_DATA`  in  `DW`  packed pixel to write.
- `WRITE_RAM`  in  1  write strobe.
- `WRITE_ERROR`  out  1  one-cycle pulse when a write is dropped.
- `CLEAR_START`  in  1  pulse that starts filling the back bank with `CLEAR_DATA`.
- `CLEAR_DATA`  in  `DW`  fill value, sampled on the `CLEAR_START` cycle.
- `CLEAR_BUSY`  out  1  high while the clear engine owns the back bank.
- `SWAP_REQ`  in  1  pulse requesting a front/back swap.
- `FRAME_END`  in  1  pulse from the painter after it has read the last pixel of a frame.
- `SWAP_PENDING`  out  1  a swap has been requested but not yet executed.
- `SWAP_DONE`  out  1  one-cycle pulse after a swap executes.
- `FRONT_BANK`  out  1  index of the bank the painter currently reads.
- `READ_RAM_ADDRESS`  in  `AW`  front-bank read address.
- `READ_RAM_EN`  in  1  read strobe.
- `READ_RAM_DATA`  out  `DW`  registered read data.
- `READ_RAM_VALID`  out  1  qualifies `READ_RAM_DATA`.

## Operation

**Storage**
- Storage is 2*`PIXEL_LIMIT` words of `DW` bits, indexed {bank, address}.
- Memory contents are not reset.

**Writes**
- A write with `WRITE_RAM`=1 goes to the back bank (~`FRONT_BANK`).
- The write is dropped, and `WRITE_ERROR` pulses on the next cycle, if either:
  - `WRITE_RAM_ADDRESS` ≥ `PIXEL_LIMIT`, or
  - `CLEAR_BUSY`=1.
- The front bank is never written.

**Clear engine FSM**
- IDLE:
  - If `CLEAR_START`=1, latch `CLEAR_DATA`, reset the counter to 0 and go to CLEAR.
  - `CLEAR_START` asserted while in CLEAR is ignored.
- CLEAR:
  - Write the latched value to back[counter] every cycle and increment the counter.
  - After writing address `PIXEL_LIMIT`-1, return to IDLE.
- `CLEAR_BUSY` = (state==CLEAR).

**Swap**
- `SWAP_REQ` sets `SWAP_PENDING`. A repeated `SWAP_REQ` while pending has no effect.
- The swap executes on a `FRAME_END` cycle when (`SWAP_PENDING` | `SWAP_REQ`) & ~`CLEAR_BUSY`. On execution:
  - `FRONT_BANK` toggles.
  - `SWAP_PENDING` clears.
  - `SWAP_DONE` pulses.
- `FRAME_END` with no request does nothing.
- `FRAME_END` while `CLEAR_BUSY`=1 does not swap. The request stays pending until a later `FRAME_END` after the clear completes.
- `CLEAR_START` on the same cycle as an executing swap: the clear targets the new back bank, i.e. the bank that was front before the edge.

**Reads**
- When `READ_RAM_EN`=1, the front bank at `READ_RAM_ADDRESS` is read, using the `FRONT_BANK` value of that cycle.
- An out-of-range read address returns all-zero data, and `READ_RAM_VALID` is still asserted.

## Timing

- **Reset values:**
  - `FRONT_BANK`=0, `SWAP_PENDING`=0, `SWAP_DONE`=0.
  - `CLEAR_BUSY`=0 (FSM in IDLE), `WRITE_ERROR`=0.
  - `READ_RAM_DATA`=0, `READ_RAM_VALID`=0.
- **Reset mid-operation:** asserting reset during CLEAR aborts the clear immediately, leaving the back bank partially filled. A pending swap is discarded.
- **Read latency:** 1 cycle. `READ_RAM_VALID` is `READ_RAM_EN` delayed by 1 cycle. `READ_RAM_DATA` holds its value when `READ_RAM_EN`=0.
- **Write:** the memory is updated at the edge that samples the strobe. `WRITE_ERROR` is registered, so it appears 1 cycle after the dropped write.
- **Clear:**
  - `CLEAR_BUSY` rises in the cycle after `CLEAR_START` and stays high for exactly `PIXEL_LIMIT` cycles.
  - The first clear write happens in the first `CLEAR_BUSY` cycle.
  - An external write in the `CLEAR_START` cycle itself is accepted.
- **Swap:** `FRONT_BANK` and `SWAP_DONE` change at the edge that samples the qualifying `FRAME_END`. `SWAP_DONE` is high for exactly one cycle.
- **Read/swap boundary:** a read issued in the same cycle as the executing `FRAME_END` uses the old front bank.

## Test plan

1. **Reset and write/read after swap.** Release reset, then check all outputs at their reset values. Write 0x112233 to back address 5, pulse `SWAP_REQ` and then `FRAME_END`, and read address 5. Required: `FRONT_BANK`=1, `SWAP_DONE` is a single-cycle pulse, and `READ_RAM_DATA`=0x112233 with `READ_RAM_VALID` one cycle after the read strobe.
2. **Front bank isolation.** Write 0xAAAAAA to address 0 with no swap, then read address 0. Required: the read returns the prior front contents, not 0xAAAAAA.
3. **Clear with blocked writes.** Pulse `CLEAR_START` with `CLEAR_DATA`=0x0000FF and write during the clear. Required:
   - `CLEAR_BUSY` is high for 57600 cycles.
   - Each write during the clear produces `WRITE_ERROR`.
   - After swap, addresses 0 and 57599 read 0x0000FF.
4. **Swap deferred by clear.** Raise `SWAP_REQ` and a `FRAME_END` while `CLEAR_BUSY`=1. Required: no swap and `SWAP_PENDING` stays 1. The next `FRAME_END` after the clear completes swaps.
5. **Out-of-range accesses.** Write to address 57600, then read address 57600. Required: `WRITE_ERROR` pulses and the read returns 0 with valid asserted.
6. **Reset mid-clear.** Assert reset 100 cycles into a clear. Required: `CLEAR_BUSY` and `SWAP_PENDING` go to 0 asynchronously, and `FRONT_BANK`=0.

Source files
------------

// File: rtl/frame_buffer_pingpong.sv
// Double-buffered frame memory. The painter reads the front bank; external
// writes and the fill engine only touch the back bank. A requested swap is
// deferred to the painter's FRAME_END so a frame is never torn.
module frame_buffer_pingpong #(
  parameter int X_LIMIT       = 240,
  parameter int Y_LIMIT       = 240,
  parameter int CHANNELS      = 3,
  parameter int CHANNEL_WIDTH = 8,
  localparam int PIXEL_LIMIT  = X_LIMIT * Y_LIMIT,
  localparam int AW           = $clog2(PIXEL_LIMIT),
  localparam int DW           = CHANNELS * CHANNEL_WIDTH
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [AW-1:0] WRITE_RAM_ADDRESS,
  input  logic [DW-1:0] WRITE_RAM_DATA,
  input  logic          WRITE_RAM,
  output logic          WRITE_ERROR,
  input  logic          CLEAR_START,
  input  logic [DW-1:0] CLEAR_DATA,
  output logic          CLEAR_BUSY,
  input  logic          SWAP_REQ,
  input  logic          FRAME_END,
  output logic          SWAP_PENDING,
  output logic          SWAP_DONE,
  output logic          FRONT_BANK,
  input  logic [AW-1:0] READ_RAM_ADDRESS,
  input  logic          READ_RAM_EN,
  output logic [DW-1:0] READ_RAM_DATA,
  output logic          READ_RAM_VALID
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [AW-1:0] LAST     = AW'(PIXEL_LIMIT - 1);
  localparam logic [AW:0]   BANK_OFS = (AW+1)'(PIXEL_LIMIT);

  // Bank 1 sits directly above bank 0, so storage is exactly two frames deep.
  function automatic logic [AW:0] mem_idx(input logic bank, input logic [AW-1:0] addr);
    return bank ? ({1'b0, addr} + BANK_OFS) : {1'b0, addr};
  endfunction

  logic [DW-1:0] mem [2*PIXEL_LIMIT];

  state_t        state, state_nxt;
  logic [AW-1:0] clr_cnt;
  logic [DW-1:0] clr_data;
  logic          clear_busy;
  logic          front, pending, do_swap, wr_ok;

  assign clear_busy = (state == CLEAR);
  // The fill engine owns the back bank while busy, so external writes lose.
  assign wr_ok      = WRITE_RAM & (WRITE_RAM_ADDRESS <= LAST) & ~clear_busy;
  // A same-cycle request counts, but never swap under a running fill.
  assign do_swap    = FRAME_END & (pending | SWAP_REQ) & ~clear_busy;

  // Fill engine state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Fill engine next state: start on CLEAR_START, stop after the last pixel
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (CLEAR_START) state_nxt = CLEAR;
      CLEAR:   if (clr_cnt == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Fill counter and latched fill value; a restart request mid-fill is ignored
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      clr_cnt  <= '0;
      clr_data <= '0;
    end else if (state == IDLE && CLEAR_START) begin
      clr_cnt  <= '0;
      clr_data <= CLEAR_DATA;
    end else if (clear_busy) begin
      clr_cnt  <= clr_cnt + 1'b1;
    end
  end

  // Single back-bank write port shared by the fill engine and the writer
  always_ff @(posedge CLK) begin
    if (clear_busy)  mem[mem_idx(~front, clr_cnt)]           <= clr_data;
    else if (wr_ok)  mem[mem_idx(~front, WRITE_RAM_ADDRESS)] <= WRITE_RAM_DATA;
  end

  // Dropped-write flag, one cycle after the offending strobe
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) WRITE_ERROR <= 1'b0;
    else        WRITE_ERROR <= WRITE_RAM & ~wr_ok;
  end

  // Swap bookkeeping: pending request, bank toggle, one-cycle done pulse
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      front     <= 1'b0;
      pending   <= 1'b0;
      SWAP_DONE <= 1'b0;
    end else begin
      front     <= front ^ do_swap;
      pending   <= do_swap ? 1'b0 : (pending | SWAP_REQ);
      SWAP_DONE <= do_swap;
    end
  end

  // Front-bank read port; data holds when idle, out-of-range reads give zero
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      READ_RAM_DATA  <= '0;
      READ_RAM_VALID <= 1'b0;
    end else begin
      READ_RAM_VALID <= READ_RAM_EN;
      if (READ_RAM_EN)
        READ_RAM_DATA <= (READ_RAM_ADDRESS <= LAST) ? mem[mem_idx(front, READ_RAM_ADDRESS)] : '0;
    end
  end

  assign CLEAR_BUSY   = clear_busy;
  assign SWAP_PENDING = pending;
  assign FRONT_BANK   = front;

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Bench for frame_buffer_pingpong: a table of per-cycle vectors for the
// write/read/swap behaviour, then hand-written fill and reset sequences.
// Read results are checked through an expected-data queue.
module tb_frame_buffer_pingpong;

  localparam int AW = 16;
  localparam int DW = 24;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [AW-1:0] WRITE_RAM_ADDRESS;
  logic [DW-1:0] WRITE_RAM_DATA;
  logic          WRITE_RAM;
  logic          WRITE_ERROR;
  logic          CLEAR_START;
  logic [DW-1:0] CLEAR_DATA;
  logic          CLEAR_BUSY;
  logic          SWAP_REQ;
  logic          FRAME_END;
  logic          SWAP_PENDING;
  logic          SWAP_DONE;
  logic          FRONT_BANK;
  logic [AW-1:0] READ_RAM_ADDRESS;
  logic          READ_RAM_EN;
  logic [DW-1:0] READ_RAM_DATA;
  logic          READ_RAM_VALID;

  frame_buffer_pingpong dut (
    .CLK(CLK), .RESET(RESET),
    .WRITE_RAM_ADDRESS(WRITE_RAM_ADDRESS), .WRITE_RAM_DATA(WRITE_RAM_DATA),
    .WRITE_RAM(WRITE_RAM), .WRITE_ERROR(WRITE_ERROR),
    .CLEAR_START(CLEAR_START), .CLEAR_DATA(CLEAR_DATA), .CLEAR_BUSY(CLEAR_BUSY),
    .SWAP_REQ(SWAP_REQ), .FRAME_END(FRAME_END), .SWAP_PENDING(SWAP_PENDING),
    .SWAP_DONE(SWAP_DONE), .FRONT_BANK(FRONT_BANK),
    .READ_RAM_ADDRESS(READ_RAM_ADDRESS), .READ_RAM_EN(READ_RAM_EN),
    .READ_RAM_DATA(READ_RAM_DATA), .READ_RAM_VALID(READ_RAM_VALID)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic [DW-1:0] rx;
    logic          sreq;
    logic          fend;
    logic          xf;   // FRONT_BANK after the edge
    logic          xe;   // WRITE_ERROR after the edge
    logic          xd;   // SWAP_DONE after the edge
    logic          xp;   // SWAP_PENDING after the edge
  } vec_t;

  vec_t          vec [16];
  logic [DW-1:0] sb [$];
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_in();
    WRITE_RAM = 1'b0; WRITE_RAM_ADDRESS = '0; WRITE_RAM_DATA = '0;
    CLEAR_START = 1'b0; CLEAR_DATA = '0;
    SWAP_REQ = 1'b0; FRAME_END = 1'b0;
    READ_RAM_EN = 1'b0; READ_RAM_ADDRESS = '0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] x);
    READ_RAM_EN = 1'b1; READ_RAM_ADDRESS = a;
    sb.push_back(x);
  endtask

  // One clock; outputs sampled 1 time unit after the edge, reads scoreboarded
  task automatic tick();
    logic ev;
    ev = READ_RAM_EN;
    @(posedge CLK); #1;
    chk("rd_valid", {31'd0, READ_RAM_VALID}, {31'd0, ev});
    if (READ_RAM_VALID) begin
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rd_extra: got %h want no read at %0t", READ_RAM_DATA, $time);
      end else begin
        chk("rd_data", {8'd0, READ_RAM_DATA}, {8'd0, sb.pop_front()});
      end
    end
  endtask

  initial begin
    int cnt;
    // we wa wd re ra rx sreq fend | xf xe xd xp
    vec[0]  = '{1'b1, 16'd5,     24'h112233, 1'b0, 16'd0,     24'h0,      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{1'b1, 16'd0,     24'h010203, 1'b0, 16'd0,     24'h0,      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[2]  = '{1'b0, 16'd0,     24'h0,      1'b0, 16'd0,     24'h0,      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vec[3]  = '{1'b0, 16'd0,     24'h0,      1'b0, 16'd0,     24'h0,      1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vec[4]  = '{1'b1, 16'd0,     24'hAAAAAA, 1'b1, 16'd5,     24'h112233, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[5]  = '{1'b0, 16'd0,     24'h0,      1'b1, 16'd0,     24'h010203, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[6]  = '{1'b0, 16'd0,     24'h0,      1'b0, 16'd0,     24'h0,      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[7]  = '{1'b1, 16'd57600, 24'h123456, 1'b1, 16'd57600, 24'h0,      1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[8]  = '{1'b0, 16'd0,     24'h0,      1'b0, 16'd0,     24'h0,      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[9]  = '{1'b0, 16'd0,     24'h0,      1'b0, 16'd0,     24'h0,      1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[10] = '{1'b0, 16'd0,     24'h0,      1'b1, 16'd0,     24'hAAAAAA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vec[11] = '{1'b0, 16'd0,     24'h0,      1'b0, 16'd0,     24'h0,      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vec[12] = '{1'b0, 16'd0,     24'h0,      1'b1, 16'd0,     24'hAAAAAA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vec[13] = '{1'b0, 16'd0,     24'h0,      1'b1, 16'd0,     24'h010203, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[14] = '{1'b0, 16'd0,     24'h0,      1'b0, 16'd0,     24'h0,      1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[15] = '{1'b0, 16'd0,     24'h0,      1'b0, 16'd0,     24'h0,      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    idle_in();
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    chk("rst_front",   {31'd0, FRONT_BANK},     32'd0);
    chk("rst_pending", {31'd0, SWAP_PENDING},   32'd0);
    chk("rst_done",    {31'd0, SWAP_DONE},      32'd0);
    chk("rst_busy",    {31'd0, CLEAR_BUSY},     32'd0);
    chk("rst_werr",    {31'd0, WRITE_ERROR},    32'd0);
    chk("rst_rdata",   {8'd0, READ_RAM_DATA},   32'd0);
    chk("rst_rvalid",  {31'd0, READ_RAM_VALID}, 32'd0);
    tick();

    // Table: writes, swap, isolation, out-of-range, read/swap boundary
    for (int i = 0; i < 16; i++) begin
      idle_in();
      WRITE_RAM = vec[i].we; WRITE_RAM_ADDRESS = vec[i].wa; WRITE_RAM_DATA = vec[i].wd;
      SWAP_REQ = vec[i].sreq; FRAME_END = vec[i].fend;
      if (vec[i].re) rd(vec[i].ra, vec[i].rx);
      tick();
      chk($sformatf("v%0d_front", i), {31'd0, FRONT_BANK},   {31'd0, vec[i].xf});
      chk($sformatf("v%0d_werr", i),  {31'd0, WRITE_ERROR},  {31'd0, vec[i].xe});
      chk($sformatf("v%0d_done", i),  {31'd0, SWAP_DONE},    {31'd0, vec[i].xd});
      chk($sformatf("v%0d_pend", i),  {31'd0, SWAP_PENDING}, {31'd0, vec[i].xp});
    end
    idle_in();
    chk("rd_hold", {8'd0, READ_RAM_DATA}, 32'h00010203);

    // Fill of back bank 0 with blocked writes, deferred swap and ignored restart
    CLEAR_START = 1'b1; CLEAR_DATA = 24'h0000FF;
    WRITE_RAM = 1'b1; WRITE_RAM_ADDRESS = 16'd3; WRITE_RAM_DATA = 24'h123456;
    tick();
    chk("clr_start_werr", {31'd0, WRITE_ERROR}, 32'd0);
    chk("clr_busy_rise",  {31'd0, CLEAR_BUSY},  32'd1);
    idle_in();
    cnt = 0;
    while (CLEAR_BUSY && cnt < 60000) begin
      if (cnt == 10) begin WRITE_RAM = 1'b1; WRITE_RAM_ADDRESS = 16'd9; WRITE_RAM_DATA = 24'h777777; end
      if (cnt == 20) begin SWAP_REQ = 1'b1; FRAME_END = 1'b1; end
      if (cnt == 30) FRAME_END = 1'b1;
      if (cnt == 40) begin CLEAR_START = 1'b1; CLEAR_DATA = 24'h00FF00; end
      tick();
      if (cnt == 10) chk("clr_wr_blocked", {31'd0, WRITE_ERROR}, 32'd1);
      if (cnt == 11) chk("clr_werr_pulse", {31'd0, WRITE_ERROR}, 32'd0);
      if (cnt == 20 || cnt == 30) begin
        chk($sformatf("clr_noswap_front_%0d", cnt), {31'd0, FRONT_BANK},   32'd1);
        chk($sformatf("clr_noswap_done_%0d", cnt),  {31'd0, SWAP_DONE},    32'd0);
        chk($sformatf("clr_noswap_pend_%0d", cnt),  {31'd0, SWAP_PENDING}, 32'd1);
      end
      idle_in();
      cnt++;
    end
    chk("clr_busy_len", cnt, 32'd57600);
    chk("clr_pend_kept", {31'd0, SWAP_PENDING}, 32'd1);
    FRAME_END = 1'b1;
    tick();
    chk("post_clr_front", {31'd0, FRONT_BANK},   32'd0);
    chk("post_clr_done",  {31'd0, SWAP_DONE},    32'd1);
    chk("post_clr_pend",  {31'd0, SWAP_PENDING}, 32'd0);
    idle_in();
    rd(16'd0, 24'h0000FF);
    tick();
    rd(16'd57599, 24'h0000FF);
    tick();
    idle_in();
    tick();

    // Reset 100 cycles into a fill with a swap pending and front bank 1
    SWAP_REQ = 1'b1; FRAME_END = 1'b1;
    tick();
    chk("pre_rst_front", {31'd0, FRONT_BANK}, 32'd1);
    idle_in(); SWAP_REQ = 1'b1;
    tick();
    idle_in(); CLEAR_START = 1'b1; CLEAR_DATA = 24'h00ABCD;
    tick();
    idle_in();
    repeat (100) tick();
    chk("pre_rst_busy", {31'd0, CLEAR_BUSY},   32'd1);
    chk("pre_rst_pend", {31'd0, SWAP_PENDING}, 32'd1);
    #2 RESET = 1'b0;
    #1;
    chk("arst_busy",  {31'd0, CLEAR_BUSY},   32'd0);
    chk("arst_pend",  {31'd0, SWAP_PENDING}, 32'd0);
    chk("arst_front", {31'd0, FRONT_BANK},   32'd0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
